// File: rtl/minmax_window_pkg.sv
// Shared types and constants for the windowed peak-to-peak monitor.
package minmax_window_pkg;

  localparam int WIN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/minmax_span_calc.sv
// Captures the tracker's min/max at window end and registers the span and
// its threshold compare; over_next is exposed so the alarm can set on the same edge.
module minmax_span_calc #(
  parameter int width = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [width-1:0] xmin,
  input  logic [width-1:0] xmax,
  input  logic [width-1:0] span_thresh,
  output logic [width-1:0] min_out,
  output logic [width-1:0] max_out,
  output logic [width-1:0] span,
  output logic             over,
  output logic             over_next
);

  logic [width-1:0] span_next;

  // Guard against an inverted pair so the span never wraps to a huge value.
  always_comb begin
    span_next = (xmin > xmax) ? '0 : (xmax - xmin);
    over_next = (span_next > span_thresh);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_out <= '0;
      max_out <= '0;
      span    <= '0;
      over    <= 1'b0;
    end else if (capture) begin
      min_out <= xmin;
      max_out <= xmax;
      span    <= span_next;
      over    <= over_next;
    end
  end

endmodule

// File: rtl/minmax_window.sv
// Windowed peak-to-peak monitor: sequences the min/max tracker's reset into
// fixed-length windows, reports min/max/span per window and a sticky alarm.
module minmax_window
  import minmax_window_pkg::*;
#(
  parameter int width = 14,
  parameter int cw    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [cw-1:0]        win_len,
  input  logic [width-1:0]     span_thresh,
  input  logic                 alarm_clr,
  input  logic [width-1:0]     xmin,
  input  logic [width-1:0]     xmax,
  output logic                 mm_reset,
  output logic [width-1:0]     min_out,
  output logic [width-1:0]     max_out,
  output logic [width-1:0]     span,
  output logic                 valid,
  output logic                 over,
  output logic                 alarm,
  output logic [WIN_CNT_W-1:0] win_count
);

  localparam logic [cw-1:0] ONE = {{(cw-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [cw-1:0]        cnt_q;
  logic [cw-1:0]        len_q;
  logic [cw-1:0]        len_eff;
  logic                 last_sample;
  logic                 latch;
  logic                 over_next;
  logic                 mm_reset_q;
  logic                 valid_q;
  logic                 alarm_q;
  logic [WIN_CNT_W-1:0] win_count_q;

  assign len_eff     = (win_len == '0) ? ONE : win_len;
  assign last_sample = (cnt_q == (len_q - ONE));
  assign latch       = (state_q == LATCH);

  // NOTE: next state is defaulted to the current state first, so no branch
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      ACCUM:   if (last_sample) state_d = LATCH;
      LATCH:   state_d = enable ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The tracker reset comes from its own flop, fed from the next state, so
  // it changes cleanly on the edge instead of through state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mm_reset_q  <= 1'b1;
      cnt_q       <= '0;
      len_q       <= ONE;
      valid_q     <= 1'b0;
      alarm_q     <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q    <= state_d;
      mm_reset_q <= (state_d != ACCUM);
      valid_q    <= latch;
      case (state_q)
        CLEAR, LATCH: begin
          len_q <= len_eff;
          cnt_q <= '0;
        end
        ACCUM:   cnt_q <= cnt_q + ONE;
        default: cnt_q <= '0;
      endcase
      if (latch) win_count_q <= win_count_q + 1'b1;
      // A new over-threshold window wins over a coincident clear.
      if (latch && over_next) alarm_q <= 1'b1;
      else if (alarm_clr)     alarm_q <= 1'b0;
    end
  end

  minmax_span_calc #(
    .width (width)
  ) u_span_calc (
    .clk         (clk),
    .reset       (reset),
    .capture     (latch),
    .xmin        (xmin),
    .xmax        (xmax),
    .span_thresh (span_thresh),
    .min_out     (min_out),
    .max_out     (max_out),
    .span        (span),
    .over        (over),
    .over_next   (over_next)
  );

  assign mm_reset  = mm_reset_q;
  assign valid     = valid_q;
  assign alarm     = alarm_q;
  assign win_count = win_count_q;

endmodule
